// File: rtl/mem_pkg.sv
// Shared definitions for the wait-state data memory: RV32I funct3 width codes
// and the access FSM state type.
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } memState_t;

   // Only these codes are meaningful for stores; unsigned variants are load-only.
   function automatic logic isStoreWidth(input logic [2:0] funct3);
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
   endfunction

endpackage

// File: rtl/data_mem_ws_if.sv
// Core-side load/store bus of the data memory; the core is the master,
// the memory is the slave.
interface data_mem_ws_if;
   logic        req;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        stall;
   logic        err;

   modport master (output req, we, funct3, a, wd, input rd, stall, err);
   modport slave  (input req, we, funct3, a, wd, output rd, stall, err);
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store
// data, extracted/extended load data and the illegal/misaligned flag.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        we,
   input  logic [1:0]  byteOffset,
   input  logic [31:0] storeIn,
   input  logic [31:0] memWord,
   output logic [3:0]  byteEn,
   output logic [31:0] storeData,
   output logic [31:0] loadData,
   output logic        accessErr
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;
   logic        illegal;
   logic        misaligned;

   assign byteSel = memWord[{byteOffset, 3'b000} +: 8];
   assign halfSel = byteOffset[1] ? memWord[31:16] : memWord[15:0];

   // Decode the width, then suppress writes and load data on any error so the
   // memory stays untouched and rd reads as zero.
   always_comb begin
      byteEn     = 4'b0000;
      storeData  = 32'h0;
      loadData   = 32'h0;
      misaligned = 1'b0;
      illegal    = we && !isStoreWidth(funct3);
      case (funct3)
         F3_B: begin
            byteEn    = 4'b0001 << byteOffset;
            storeData = {4{storeIn[7:0]}};
            loadData  = {{24{byteSel[7]}}, byteSel};
         end
         F3_H: begin
            misaligned = byteOffset[0];
            byteEn     = byteOffset[1] ? 4'b1100 : 4'b0011;
            storeData  = {2{storeIn[15:0]}};
            loadData   = {{16{halfSel[15]}}, halfSel};
         end
         F3_W: begin
            misaligned = |byteOffset;
            byteEn     = 4'b1111;
            storeData  = storeIn;
            loadData   = memWord;
         end
         F3_BU: begin
            loadData = {24'h0, byteSel};
         end
         F3_HU: begin
            misaligned = byteOffset[0];
            loadData   = {16'h0, halfSel};
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
      accessErr = illegal || misaligned;
      if (accessErr || !we) begin
         byteEn = 4'b0000;
      end
      if (accessErr || we) begin
         loadData = 32'h0;
      end
   end

endmodule

// File: rtl/data_mem_ws.sv
// Word-organised data memory with a configurable number of stall cycles per
// access, byte-lane stores and RV32I load extension.
module data_mem_ws
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic clk,
   input  logic reset,
   data_mem_ws_if.slave bus
);

   localparam int         AW         = $clog2(DEPTH_WORDS);
   localparam bit         NO_WAIT    = (WAIT_STATES == 0);
   localparam logic [3:0] LOAD_COUNT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [31:0] mem [DEPTH_WORDS];

   memState_t   state;
   logic [3:0]  waitCount;
   logic [31:0] latchAddr;
   logic [31:0] latchWd;
   logic        latchWe;
   logic [2:0]  latchFunct3;

   logic [31:0] accAddr;
   logic [31:0] accWd;
   logic        accWe;
   logic [2:0]  accFunct3;
   logic        accActive;

   logic [AW-1:0] wordIndex;
   logic [31:0]   memWord;
   logic [3:0]    byteEn;
   logic [31:0]   storeData;
   logic [31:0]   loadData;
   logic          accessErr;
   logic          memWrite;
   logic          unusedAddrBits;

   // Without wait states the live bus is the access; otherwise the latched
   // request is, and only in DONE does it produce a result.
   always_comb begin
      accAddr   = latchAddr;
      accWd     = latchWd;
      accWe     = latchWe;
      accFunct3 = latchFunct3;
      accActive = (state == DONE);
      if (NO_WAIT) begin
         accAddr   = bus.a;
         accWd     = bus.wd;
         accWe     = bus.we;
         accFunct3 = bus.funct3;
         accActive = bus.req;
      end
   end

   assign wordIndex      = accAddr[AW+1:2];
   assign unusedAddrBits = ^accAddr[31:AW+2];
   assign memWord        = mem[wordIndex];

   mem_lane_align u_align (
      .funct3     (accFunct3),
      .we         (accWe),
      .byteOffset (accAddr[1:0]),
      .storeIn    (accWd),
      .memWord    (memWord),
      .byteEn     (byteEn),
      .storeData  (storeData),
      .loadData   (loadData),
      .accessErr  (accessErr)
   );

   assign memWrite  = accActive && !reset;
   assign bus.stall = !reset && !NO_WAIT && (((state == IDLE) && bus.req) || (state == WAIT));
   assign bus.rd    = memWrite ? loadData : 32'h0;
   assign bus.err   = memWrite && accessErr;

   // Access sequencer. The IDLE cycle that accepts a request is itself the
   // first stall cycle, so the counter holds the WAIT cycles still to come.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         waitCount   <= 4'd0;
         latchAddr   <= 32'h0;
         latchWd     <= 32'h0;
         latchWe     <= 1'b0;
         latchFunct3 <= 3'b000;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req && !NO_WAIT) begin
                  latchAddr   <= bus.a;
                  latchWd     <= bus.wd;
                  latchWe     <= bus.we;
                  latchFunct3 <= bus.funct3;
                  waitCount   <= LOAD_COUNT;
                  state       <= (WAIT_STATES == 1) ? DONE : WAIT;
               end
            end
            WAIT: begin
               if (!bus.req) begin
                  waitCount <= 4'd0;
                  state     <= IDLE;
               end else begin
                  waitCount <= waitCount - 4'd1;
                  if (waitCount == 4'd1) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Storage is deliberately outside reset so contents survive a core reset.
   always_ff @(posedge clk) begin
      if (memWrite) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (byteEn[lane]) begin
               mem[wordIndex][lane*8 +: 8] <= storeData[lane*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_ws.sv
// Scoreboard bench for data_mem_ws with zero, two and three wait states;
// expected completions are queued at issue and consumed by a monitor.
module tb_data_mem_ws;
   import mem_pkg::*;

   typedef struct {
      string       name;
      logic [31:0] rd;
      logic        err;
      bit          checkRd;
   } expect_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   int totalChecks = 0;
   int passChecks = 0;
   bit sawStall0 = 1'b0;

   expect_t sbQ0[$];
   expect_t sbQ1[$];
   expect_t sbQ2[$];

   data_mem_ws_if bus0 ();
   data_mem_ws_if bus2 ();
   data_mem_ws_if bus3 ();

   data_mem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   data_mem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
   data_mem_ws #(.DEPTH_WORDS(64), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      totalChecks++;
      if (actual === expected) begin
         passChecks++;
      end else begin
         $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
      end
   endtask

   function automatic int waitOf(input int inst);
      return (inst == 0) ? 0 : ((inst == 1) ? 2 : 3);
   endfunction

   function automatic logic getStall(input int inst);
      case (inst)
         0:       return bus0.stall;
         1:       return bus2.stall;
         default: return bus3.stall;
      endcase
   endfunction

   function automatic logic [31:0] getRd(input int inst);
      case (inst)
         0:       return bus0.rd;
         1:       return bus2.rd;
         default: return bus3.rd;
      endcase
   endfunction

   function automatic logic getErr(input int inst);
      case (inst)
         0:       return bus0.err;
         1:       return bus2.err;
         default: return bus3.err;
      endcase
   endfunction

   task automatic driveBus(input int inst, input logic rq, input logic w, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
      case (inst)
         0: begin bus0.req = rq; bus0.we = w; bus0.funct3 = f3; bus0.a = addr; bus0.wd = wdata; end
         1: begin bus2.req = rq; bus2.we = w; bus2.funct3 = f3; bus2.a = addr; bus2.wd = wdata; end
         default: begin bus3.req = rq; bus3.we = w; bus3.funct3 = f3; bus3.a = addr; bus3.wd = wdata; end
      endcase
   endtask

   task automatic pushExpect(input int inst, input string name, input logic [31:0] rd,
                             input logic err, input bit chkRd);
      expect_t e;
      e.name = name;
      e.rd = rd;
      e.err = err;
      e.checkRd = chkRd;
      case (inst)
         0:       sbQ0.push_back(e);
         1:       sbQ1.push_back(e);
         default: sbQ2.push_back(e);
      endcase
   endtask

   task automatic popCheck(input int inst, input logic [31:0] rd, input logic err);
      expect_t e;
      bit have = 1'b0;
      case (inst)
         0: if (sbQ0.size() > 0) begin e = sbQ0.pop_front(); have = 1'b1; end
         1: if (sbQ1.size() > 0) begin e = sbQ1.pop_front(); have = 1'b1; end
         default: if (sbQ2.size() > 0) begin e = sbQ2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         totalChecks++;
         $display("[TB] FAIL unexpected completion on inst %0d: rd=%h err=%b, required no completion", inst, rd, err);
      end else begin
         if (e.checkRd) begin
            checkOutput({e.name, " rd"}, rd, e.rd);
         end
         checkOutput({e.name, " err"}, {31'b0, err}, {31'b0, e.err});
      end
   endtask

   // Completion monitor: a held request with stall low is a finished access.
   always @(negedge clk) begin
      if (bus0.stall) sawStall0 = 1'b1;
      if (!reset) begin
         if (bus0.req && !bus0.stall) popCheck(0, bus0.rd, bus0.err);
         if (bus2.req && !bus2.stall) popCheck(1, bus2.rd, bus2.err);
         if (bus3.req && !bus3.stall) popCheck(2, bus3.rd, bus3.err);
      end
   end

   task automatic applyStimulus(input int inst, input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRd, input logic expErr,
                                input bit chkRd, input string name);
      int stalls = 0;
      bit done = 1'b0;
      @(posedge clk); #1;
      driveBus(inst, 1'b1, w, f3, addr, wdata);
      pushExpect(inst, name, expRd, expErr, chkRd);
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (getStall(inst)) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         totalChecks++;
         $display("[TB] FAIL %s timeout: no completion in 40 cycles, required completion", name);
      end else begin
         checkOutput({name, " stalls"}, stalls, waitOf(inst));
      end
   endtask

   task automatic idleBus(input int inst);
      @(posedge clk); #1;
      driveBus(inst, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      driveBus(0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      driveBus(1, 1'b1, 1'b0, F3_W, 32'h10, 32'h0);
      driveBus(2, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      #3;
      checkOutput("reset stall", {31'b0, bus2.stall}, 32'h0);
      checkOutput("reset rd", bus2.rd, 32'h0);
      checkOutput("reset err", {31'b0, bus2.err}, 32'h0);
      driveBus(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Zero wait states: combinational completion
      applyStimulus(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "n0 sw 0x10");
      applyStimulus(0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "n0 lw 0x10");
      applyStimulus(0, 1'b0, F3_H, 32'h11, 32'h0, 32'h0, 1'b1, 1'b1, "n0 lh 0x11");
      idleBus(0);
      #1;
      checkOutput("n0 idle rd", bus0.rd, 32'h0);
      checkOutput("n0 idle err", {31'b0, bus0.err}, 32'h0);

      // Two wait states, issued back-to-back
      applyStimulus(1, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, "n2 sw 0x10");
      applyStimulus(1, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "n2 lw 0x10");
      applyStimulus(1, 1'b1, F3_B, 32'h11, 32'h00000055, 32'h0, 1'b0, 1'b0, "n2 sb 0x11");
      applyStimulus(1, 1'b0, F3_B, 32'h11, 32'h0, 32'h00000055, 1'b0, 1'b1, "n2 lb 0x11");
      applyStimulus(1, 1'b0, F3_BU, 32'h13, 32'h0, 32'h000000DE, 1'b0, 1'b1, "n2 lbu 0x13");
      applyStimulus(1, 1'b0, F3_H, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b1, "n2 lh 0x12");
      applyStimulus(1, 1'b0, F3_W, 32'h12, 32'h0, 32'h0, 1'b1, 1'b1, "n2 lw 0x12");
      applyStimulus(1, 1'b1, F3_H, 32'h13, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, "n2 sh 0x13");
      applyStimulus(1, 1'b1, F3_BU, 32'h10, 32'h000000FF, 32'h0, 1'b1, 1'b0, "n2 sbu illegal");
      applyStimulus(1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1'b1, "n2 ld illegal");
      applyStimulus(1, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 1'b1, "n2 lw after err");
      applyStimulus(1, 1'b0, F3_HU, 32'h10, 32'h0, 32'h000055EF, 1'b0, 1'b1, "n2 lhu 0x10");
      applyStimulus(1, 1'b0, F3_B, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0, 1'b1, "n2 lb 0x10");
      applyStimulus(1, 1'b1, F3_H, 32'h12, 32'h00001234, 32'h0, 1'b0, 1'b0, "n2 sh 0x12");
      applyStimulus(1, 1'b0, F3_W, 32'h10, 32'h0, 32'h123455EF, 1'b0, 1'b1, "n2 lw after sh");
      applyStimulus(1, 1'b1, F3_W, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, "n2 sw 0x100");
      applyStimulus(1, 1'b0, F3_W, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, "n2 lw wrap 0x0");
      idleBus(1);

      // Three wait states with an abort in the second WAIT cycle
      applyStimulus(2, 1'b1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, "n3 sw 0x20");
      idleBus(2);
      @(posedge clk); #1;
      driveBus(2, 1'b1, 1'b1, F3_W, 32'h20, 32'h12345678);
      @(posedge clk); #1;
      @(posedge clk); #1;
      driveBus(2, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      @(posedge clk); #1;
      checkOutput("n3 abort stall", {31'b0, bus3.stall}, 32'h0);
      checkOutput("n3 abort err", {31'b0, bus3.err}, 32'h0);
      applyStimulus(2, 1'b0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, "n3 lw after abort");
      idleBus(2);

      // Reset in the middle of a WAIT cancels the store, keeps memory
      @(posedge clk); #1;
      driveBus(1, 1'b1, 1'b1, F3_W, 32'h0, 32'h11111111);
      @(posedge clk); #1;
      checkOutput("n2 stall in WAIT", {31'b0, bus2.stall}, 32'h1);
      #1 reset = 1'b1;
      #1;
      checkOutput("midreset stall", {31'b0, bus2.stall}, 32'h0);
      checkOutput("midreset rd", bus2.rd, 32'h0);
      checkOutput("midreset err", {31'b0, bus2.err}, 32'h0);
      driveBus(1, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      @(posedge clk); #1;
      reset = 1'b0;
      applyStimulus(1, 1'b0, F3_W, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b1, "n2 lw after reset");
      idleBus(1);

      @(posedge clk); #1;
      checkOutput("n0 stall never seen", {31'b0, sawStall0}, 32'h0);
      checkOutput("scoreboard drained", sbQ0.size() + sbQ1.size() + sbQ2.size(), 32'h0);
      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule

// File: doc/data_mem_ws.md
DATA_MEM_WS -- requirements
Module: data_mem_ws

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, stall cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  core access request; held with a/wd/we/funct3 while stall=1.
REQ-006 SHALL have port we  input  1  1=store, 0=load.
REQ-007 SHALL have port funct3  input  3  RV32I width/sign code.
REQ-008 SHALL have port a  input  32  byte address.
REQ-009 SHALL have port wd  input  32  store data, right-aligned.
REQ-010 SHALL have port rd  output  32  load data, extended per funct3.
REQ-011 SHALL have port stall  output  1  1=core must hold PC and request.
REQ-012 SHALL have port err  output  1  misaligned/illegal access, valid in completion cycle.

Function
REQ-013 Word index SHALL be a[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap modulo DEPTH_WORDS*4).
REQ-014 Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores: 000 sb, 001 sh, 010 sw; any other funct3 SHALL set err.
REQ-015 Halfword at a[0]=1 or word at a[1:0]!=0 SHALL set err; erroneous access SHALL write nothing and return rd=0.
REQ-016 Stores SHALL modify only addressed byte lanes; lb/lh sign-extend, lbu/lhu zero-extend from addressed lane.
REQ-017 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-018 WAIT_STATES=0: IDLE only; stall=0; rd/err combinational from current inputs; store commits at rising edge where req=1.
REQ-019 WAIT_STATES=N>0, IDLE with req=1: stall=1, latch a/wd/we/funct3, load counter N-1, next WAIT.
REQ-020 WAIT: stall=1; counter decrements each cycle; counter=0 -> DONE.
REQ-021 DONE: stall=0, rd/err from latched request; store commits at edge leaving DONE; next IDLE.
REQ-022 Access latency SHALL be exactly N stall cycles; completion in cycle N+1 after req first seen.
REQ-023 req=0 while in WAIT SHALL abort: next IDLE, no write, no err.
REQ-024 IDLE with req=0: stall=0, rd=0, err=0.
REQ-025 Back-to-back requests: req=1 in the cycle after DONE SHALL start a new access from IDLE without gap cycles.

Reset
REQ-026 reset=1 SHALL immediately force state IDLE, counter 0, latched request cleared, stall=0, rd=0, err=0.
REQ-027 Reset mid-access SHALL cancel any pending store; memory array contents SHALL NOT be cleared by reset.

Structure
REQ-028 Package mem_pkg SHALL hold funct3 encoding constants and state enum type.
REQ-029 Combinational sub-module mem_lane_align SHALL compute byte enables, store lane shift, load extraction/extension and err.
REQ-030 Memory array SHALL be a DEPTH_WORDS x 32 register array written with byte-lane enables.

Verification
REQ-031 N=0: sw 0xDEADBEEF @0x10, then lw @0x10 -> rd=0xDEADBEEF, stall never 1.
REQ-032 N=2: lw @0x10 -> stall=1 for 2 cycles, third cycle stall=0 and rd=0xDEADBEEF.
REQ-033 After sw 0xDEADBEEF @0x10: sb 0x55 @0x11, lb @0x11 -> 0x00000055; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD.
REQ-034 lw @0x12 or sh @0x13 -> err=1 in completion cycle, rd=0, memory word unchanged.
REQ-035 N=3: sw 0x12345678 @0x20, drop req in second WAIT cycle -> IDLE next cycle, lw @0x20 returns old value.
REQ-036 DEPTH_WORDS=64: sw 0xA5A5A5A5 @0x100 then lw @0x0 -> 0xA5A5A5A5; reset asserted mid-WAIT -> stall/rd/err 0 same cycle.
